// File: rtl/pe_mac_v2_pkg.sv
// Shared types and fixed-point helpers for the pe_mac_v2 processing element.
package pe_pkg;

  typedef enum logic {
    PE_WS = 1'b0,
    PE_OS = 1'b1
  } pe_mode_e;

  // Half-LSB rounding constant for a given number of fractional bits.
  function automatic logic signed [63:0] rnd_const(input int unsigned frac);
    return 64'sd1 <<< (frac - 32'd1);
  endfunction

  // Clamp a wide signed value into the signed range of a w-bit word.
  function automatic logic signed [63:0] sat_to_psum(input logic signed [63:0] x,
                                                     input int unsigned w);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (w - 32'd1)) - 64'sd1;
    min_v = -(64'sd1 <<< (w - 32'd1));
    if (x > max_v) begin
      return max_v;
    end else if (x < min_v) begin
      return min_v;
    end else begin
      return x;
    end
  endfunction

  localparam int unsigned DEF_FRAC_BITS = 32'd8;
  localparam logic signed [63:0] DEF_RND = rnd_const(DEF_FRAC_BITS);

endpackage

// File: rtl/pe_mac_v2_if.sv
// Systolic PE neighbour bus: north/west inputs and south/east outputs.
interface pe_mac_v2_if #(
  parameter int DATA_WIDTH = 16,
  parameter int PSUM_WIDTH = 16
);
  logic                  en;
  logic                  mode;
  logic                  clr_ovf;
  logic [PSUM_WIDTH-1:0] psum_in;
  logic                  psum_valid_in;
  logic [DATA_WIDTH-1:0] weight_in;
  logic                  weight_valid_in;
  logic [DATA_WIDTH-1:0] input_in;
  logic                  valid_in;
  logic                  switch_in;
  logic                  drain_in;
  logic [PSUM_WIDTH-1:0] psum_out;
  logic                  psum_valid_out;
  logic [DATA_WIDTH-1:0] weight_out;
  logic                  weight_valid_out;
  logic [DATA_WIDTH-1:0] input_out;
  logic                  valid_out;
  logic                  switch_out;
  logic                  drain_out;
  logic                  ovf_sticky;

  modport slave (
    input  en, mode, clr_ovf, psum_in, psum_valid_in, weight_in, weight_valid_in,
           input_in, valid_in, switch_in, drain_in,
    output psum_out, psum_valid_out, weight_out, weight_valid_out, input_out,
           valid_out, switch_out, drain_out, ovf_sticky
  );

  modport master (
    output en, mode, clr_ovf, psum_in, psum_valid_in, weight_in, weight_valid_in,
           input_in, valid_in, switch_in, drain_in,
    input  psum_out, psum_valid_out, weight_out, weight_valid_out, input_out,
           valid_out, switch_out, drain_out, ovf_sticky
  );
endinterface

// File: rtl/pe_mac_v2_fxp_mul_rnd_sat.sv
// Signed fixed-point multiply with round-half-up and saturation to psum width.
module fxp_mul_rnd_sat
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int PSUM_WIDTH = 16
) (
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [PSUM_WIDTH-1:0] prod,
  output logic                         ovf
);
  localparam logic signed [63:0] RND = rnd_const(FRAC_BITS);

  logic signed [2*DATA_WIDTH-1:0] p_s;
  logic signed [63:0]             wide_s;
  logic signed [63:0]             sat_s;

  // Full product, rounded back to FRAC_BITS, then clamped to the psum range.
  always_comb begin
    p_s    = a * b;
    wide_s = (64'(p_s) + RND) >>> FRAC_BITS;
    sat_s  = sat_to_psum(wide_s, PSUM_WIDTH);
    prod   = sat_s[PSUM_WIDTH-1:0];
    ovf    = (sat_s != wide_s);
  end
endmodule

// File: rtl/pe_mac_v2.sv
// Weight-/output-stationary systolic MAC processing element with stall and drain chain.
module pe_mac_v2
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int PSUM_WIDTH = 16
) (
  input logic        clk,
  input logic        rst,
  pe_mac_v2_if.slave bus
);
  logic signed [DATA_WIDTH-1:0] active_q, active_d, shadow_q, shadow_d, eff_weight_s;
  logic signed [PSUM_WIDTH-1:0] acc_q, acc_d, psum_out_q, psum_out_d, prod_s;
  logic [DATA_WIDTH-1:0]        weight_out_q, weight_out_d, input_out_q, input_out_d;
  logic psum_valid_out_q, psum_valid_out_d, weight_valid_out_q, weight_valid_out_d;
  logic valid_out_q, valid_out_d, switch_out_q, switch_out_d, drain_out_q, drain_out_d;
  logic ovf_q, ovf_d, ovf_set_s, prod_ovf_s;
  logic ws_ovf_s, acc_ovf_s, drain_ovf_s;
  pe_mode_e mode_q, mode_d, mode_in_s;
  logic signed [63:0] ws_raw_s, ws_sat_s, acc_raw_s, acc_sat_s, drain_raw_s, drain_sat_s;

  // A switch cycle already multiplies by the weight being promoted.
  always_comb begin
    eff_weight_s = bus.switch_in ? shadow_q : active_q;
    mode_in_s    = pe_mode_e'(bus.mode);
  end

  fxp_mul_rnd_sat #(
    .DATA_WIDTH(DATA_WIDTH),
    .FRAC_BITS (FRAC_BITS),
    .PSUM_WIDTH(PSUM_WIDTH)
  ) u_mul (
    .a   ($signed(bus.input_in)),
    .b   (eff_weight_s),
    .prod(prod_s),
    .ovf (prod_ovf_s)
  );

  // Candidate sums for the three consumers of the product, each saturated.
  always_comb begin
    ws_raw_s    = 64'($signed(bus.psum_in)) + 64'(prod_s);
    ws_sat_s    = sat_to_psum(ws_raw_s, PSUM_WIDTH);
    ws_ovf_s    = (ws_sat_s != ws_raw_s);
    acc_raw_s   = 64'(acc_q) + 64'(prod_s);
    acc_sat_s   = sat_to_psum(acc_raw_s, PSUM_WIDTH);
    acc_ovf_s   = (acc_sat_s != acc_raw_s);
    drain_raw_s = 64'(acc_q) + (bus.valid_in ? 64'(prod_s) : 64'sd0);
    drain_sat_s = sat_to_psum(drain_raw_s, PSUM_WIDTH);
    drain_ovf_s = (drain_sat_s != drain_raw_s);
  end

  // Next-state logic; with en low everything holds.
  always_comb begin
    active_d = active_q;                 shadow_d = shadow_q;
    acc_d = acc_q;                       psum_out_d = psum_out_q;
    psum_valid_out_d = psum_valid_out_q; weight_out_d = weight_out_q;
    weight_valid_out_d = weight_valid_out_q;
    input_out_d = input_out_q;           valid_out_d = valid_out_q;
    switch_out_d = switch_out_q;         drain_out_d = drain_out_q;
    mode_d = mode_q;                     ovf_d = ovf_q;
    ovf_set_s = 1'b0;
    if (bus.en) begin
      mode_d             = mode_in_s;
      valid_out_d        = bus.valid_in;
      switch_out_d       = bus.switch_in;
      drain_out_d        = bus.drain_in;
      input_out_d        = bus.valid_in ? bus.input_in : {DATA_WIDTH{1'b0}};
      weight_out_d       = bus.weight_valid_in ? bus.weight_in : {DATA_WIDTH{1'b0}};
      weight_valid_out_d = bus.weight_valid_in;
      shadow_d           = bus.weight_valid_in ? $signed(bus.weight_in) : shadow_q;
      active_d           = bus.switch_in ? shadow_q : active_q;
      psum_out_d         = {PSUM_WIDTH{1'b0}};
      psum_valid_out_d   = 1'b0;
      if (mode_in_s != mode_q) begin
        // Mode transition: flush the accumulator and discard this cycle's MAC.
        acc_d = {PSUM_WIDTH{1'b0}};
      end else if (mode_in_s == PE_WS) begin
        acc_d = {PSUM_WIDTH{1'b0}};
        if (bus.valid_in) begin
          psum_out_d       = ws_sat_s[PSUM_WIDTH-1:0];
          psum_valid_out_d = 1'b1;
          ovf_set_s        = prod_ovf_s | ws_ovf_s;
        end else begin
          psum_valid_out_d = 1'b0;
        end
      end else begin
        if (bus.drain_in) begin
          // Drain beats an upstream word; the dropped word is flagged as an error.
          psum_out_d       = drain_sat_s[PSUM_WIDTH-1:0];
          psum_valid_out_d = 1'b1;
          acc_d            = {PSUM_WIDTH{1'b0}};
          ovf_set_s        = (bus.valid_in & (prod_ovf_s | drain_ovf_s)) | bus.psum_valid_in;
        end else if (bus.valid_in) begin
          acc_d            = acc_sat_s[PSUM_WIDTH-1:0];
          ovf_set_s        = prod_ovf_s | acc_ovf_s;
          psum_out_d       = bus.psum_valid_in ? bus.psum_in : {PSUM_WIDTH{1'b0}};
          psum_valid_out_d = bus.psum_valid_in;
        end else begin
          psum_out_d       = bus.psum_valid_in ? bus.psum_in : {PSUM_WIDTH{1'b0}};
          psum_valid_out_d = bus.psum_valid_in;
        end
      end
      if (ovf_set_s) begin
        ovf_d = 1'b1;
      end else if (bus.clr_ovf) begin
        ovf_d = 1'b0;
      end else begin
        ovf_d = ovf_q;
      end
    end else begin
      ovf_set_s = 1'b0;
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= '0;            shadow_q <= '0;       acc_q <= '0;
      psum_out_q <= '0;          psum_valid_out_q <= 1'b0;
      weight_out_q <= '0;        weight_valid_out_q <= 1'b0;
      input_out_q <= '0;         valid_out_q <= 1'b0;
      switch_out_q <= 1'b0;      drain_out_q <= 1'b0;
      mode_q <= PE_WS;           ovf_q <= 1'b0;
    end else begin
      active_q <= active_d;      shadow_q <= shadow_d;  acc_q <= acc_d;
      psum_out_q <= psum_out_d;  psum_valid_out_q <= psum_valid_out_d;
      weight_out_q <= weight_out_d; weight_valid_out_q <= weight_valid_out_d;
      input_out_q <= input_out_d; valid_out_q <= valid_out_d;
      switch_out_q <= switch_out_d; drain_out_q <= drain_out_d;
      mode_q <= mode_d;          ovf_q <= ovf_d;
    end
  end

  assign bus.psum_out         = psum_out_q;
  assign bus.psum_valid_out   = psum_valid_out_q;
  assign bus.weight_out       = weight_out_q;
  assign bus.weight_valid_out = weight_valid_out_q;
  assign bus.input_out        = input_out_q;
  assign bus.valid_out        = valid_out_q;
  assign bus.switch_out       = switch_out_q;
  assign bus.drain_out        = drain_out_q;
  assign bus.ovf_sticky       = ovf_q;
endmodule
